// File: rtl/pfpu_pkg.sv
// pfpu_pkg: shared mesh sequencer widths and state encoding
package pfpu_pkg;
  localparam int MESH_W = 7;
  localparam int VCOUNT_W = 15;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FIRST  = 3'd1,
    S_SETTLE = 3'd2,
    S_PROG   = 3'd3,
    S_DMA    = 3'd4,
    S_NEXT   = 3'd5
  } state_e;
endpackage

// File: rtl/pfpu_mesh_seq_if.sv
// pfpu_mesh_seq_if: control bus of the mesh sequencer
// master drives start/abort/mesh size/prog_done/dma_ack and observes the rest;
// slave (the sequencer) drives indices, prog_start, dma_en, busy, irq, vcount.
interface pfpu_mesh_seq_if;
  import pfpu_pkg::*;
  logic                start;
  logic                abort;
  logic [MESH_W-1:0]   hmesh_last;
  logic [MESH_W-1:0]   vmesh_last;
  logic [31:0]         r0;
  logic [31:0]         r1;
  logic                prog_start;
  logic                prog_done;
  logic                dma_en;
  logic                dma_ack;
  logic                busy;
  logic                irq;
  logic [VCOUNT_W-1:0] vcount;
  modport master (
    output start, abort, hmesh_last, vmesh_last, prog_done, dma_ack,
    input  r0, r1, prog_start, dma_en, busy, irq, vcount
  );
  modport slave (
    input  start, abort, hmesh_last, vmesh_last, prog_done, dma_ack,
    output r0, r1, prog_start, dma_en, busy, irq, vcount
  );
endinterface

// File: rtl/pfpu_counters.sv
// pfpu_counters: row-major mesh index counters with a registered last flag
// first clears both indices, next advances r0 and wraps into r1;
// last is (r0,r1) == (hmesh_last,vmesh_last) delayed by one cycle.
module pfpu_counters
  import pfpu_pkg::*;
(
  input  logic              sys_clk,
  input  logic              first,
  input  logic              next,
  input  logic [MESH_W-1:0] hmesh_last,
  input  logic [MESH_W-1:0] vmesh_last,
  output logic [MESH_W-1:0] r0,
  output logic [MESH_W-1:0] r1,
  output logic              last
);
  logic [MESH_W-1:0] r0_q, r0_d, r1_q, r1_d;
  logic last_q, last_d;
  logic wrap;
  always_comb begin
    wrap   = r0_q == hmesh_last;
    r0_d   = first ? '0 : next ? (wrap ? '0 : r0_q + 1'b1) : r0_q;
    r1_d   = first ? '0 : (next && wrap) ? r1_q + 1'b1 : r1_q;
    last_d = wrap && (r1_q == vmesh_last);
  end
  // Deliberately unreset: indices are only meaningful after a first pulse.
  always_ff @(posedge sys_clk) begin
    r0_q   <= r0_d;
    r1_q   <= r1_d;
    last_q <= last_d;
  end
  assign r0   = r0_q;
  assign r1   = r1_q;
  assign last = last_q;
endmodule

// File: rtl/pfpu_mesh_seq.sv
// pfpu_mesh_seq: walks a mesh vertex by vertex, launching the program and a DMA write per vertex
// Ports: sys_clk, sys_rst_n (async, active-low), bus (pfpu_mesh_seq_if.slave).
module pfpu_mesh_seq
  import pfpu_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  pfpu_mesh_seq_if.slave   bus
);
  state_e state_q, state_d;
  logic prog_start_q, prog_start_d, irq_q, irq_d;
  logic [VCOUNT_W-1:0] vcount_q, vcount_d;
  logic [MESH_W-1:0] r0, r1;
  logic first, next, last, wr_done;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = bus.start ? S_FIRST : S_IDLE;
      S_FIRST:  state_d = S_SETTLE;
      S_SETTLE: state_d = S_PROG;
      S_PROG:   state_d = bus.prog_done ? S_DMA : S_PROG;
      S_DMA:    state_d = bus.dma_ack ? (last ? S_IDLE : S_NEXT) : S_DMA;
      S_NEXT:   state_d = S_SETTLE;
      default:  state_d = S_IDLE;
    endcase
    if (bus.abort) state_d = S_IDLE;
    wr_done      = state_q == S_DMA && bus.dma_ack && !bus.abort;
    prog_start_d = state_d == S_PROG && state_q != S_PROG;
    irq_d        = wr_done && last;
    vcount_d     = state_q == S_FIRST ? '0 : wr_done ? vcount_q + 1'b1 : vcount_q;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      prog_start_q <= 1'b0;
      irq_q        <= 1'b0;
      vcount_q     <= '0;
    end else begin
      state_q      <= state_d;
      prog_start_q <= prog_start_d;
      irq_q        <= irq_d;
      vcount_q     <= vcount_d;
    end
  end
  assign first = state_q == S_FIRST;
  assign next  = state_q == S_NEXT;
  pfpu_counters u_cnt (
    .sys_clk    (sys_clk),
    .first      (first),
    .next       (next),
    .hmesh_last (bus.hmesh_last),
    .vmesh_last (bus.vmesh_last),
    .r0         (r0),
    .r1         (r1),
    .last       (last)
  );
  assign bus.r0         = {{(32-MESH_W){1'b0}}, r0};
  assign bus.r1         = {{(32-MESH_W){1'b0}}, r1};
  assign bus.prog_start = prog_start_q;
  assign bus.dma_en     = state_q == S_DMA;
  assign bus.busy       = state_q != S_IDLE;
  assign bus.irq        = irq_q;
  assign bus.vcount     = vcount_q;
endmodule

// File: tb/tb_pfpu_mesh_seq.sv
// tb_pfpu_mesh_seq: randomized self-checking bench for the mesh sequencer
module tb_pfpu_mesh_seq;
  logic sys_clk = 1'b0;
  logic sys_rst_n;
  int checks = 0;
  int failures = 0;
  logic [31:0] obs_r0[$];
  logic [31:0] obs_r1[$];
  int obs_len[$];
  int n_irq, n_ps;
  bit timed_out;
  pfpu_mesh_seq_if bus();
  pfpu_mesh_seq dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));
  always #5 sys_clk = ~sys_clk;

  // Row-major reference: vertex k must be (k mod (h+1), k div (h+1)).
  function automatic int seq_errs(input int h, input int v);
    int e = 0;
    int n = int'(obs_r0.size());
    if (n != (h + 1) * (v + 1)) e++;
    for (int k = 0; k < n; k++)
      if (obs_r0[k] !== 32'(k % (h + 1)) || obs_r1[k] !== 32'(k / (h + 1))) e++;
    return e;
  endfunction

  // Acts as vertex program and DMA target for one mesh, recording what it sees.
  // ack_dly<0 picks a random ack delay per vertex; abort_at/start_at are vertex
  // indices at which to inject abort (with the ack) or a stray start (in PROG).
  task automatic drive_mesh(input int h, input int v, input int ack_dly, input bit prog_rand,
                            input int abort_at, input int start_at, input int max_cycles);
    int pd = -1;
    int dlen = 0;
    int cur = 0;
    obs_r0.delete(); obs_r1.delete(); obs_len.delete();
    n_irq = 0; n_ps = 0; timed_out = 1;
    bus.hmesh_last = 7'(h); bus.vmesh_last = 7'(v);
    bus.start = 1'b1;
    @(negedge sys_clk);
    for (int c = 0; c < max_cycles; c++) begin
      bus.start = 1'b0; bus.abort = 1'b0; bus.prog_done = 1'b0; bus.dma_ack = 1'b0;
      if (bus.irq) n_irq++;
      if (!bus.busy) begin
        timed_out = 0;
        break;
      end
      if (bus.prog_start) begin
        n_ps++;
        pd = prog_rand ? int'($urandom_range(0, 3)) : 0;
        if (int'(obs_r0.size()) == start_at) bus.start = 1'b1;
      end
      if (pd == 0) bus.prog_done = 1'b1;
      if (pd >= 0) pd--;
      if (bus.dma_en) begin
        if (dlen == 0) begin
          obs_r0.push_back(bus.r0);
          obs_r1.push_back(bus.r1);
          cur = ack_dly < 0 ? int'($urandom_range(0, 3)) : ack_dly;
        end
        dlen++;
        if (dlen > cur) begin
          bus.dma_ack = 1'b1;
          obs_len.push_back(dlen);
          dlen = 0;
          if (int'(obs_r0.size()) - 1 == abort_at) bus.abort = 1'b1;
        end
      end
      @(negedge sys_clk);
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.prog_done = 1'b0; bus.dma_ack = 1'b0;
    repeat (4) begin
      @(negedge sys_clk);
      if (bus.irq) n_irq++;
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    bus.start = 0; bus.abort = 0; bus.prog_done = 0; bus.dma_ack = 0;
    bus.hmesh_last = '0; bus.vmesh_last = '0;
    repeat (2) @(negedge sys_clk);
    checks++;
    if ({bus.busy, bus.dma_en, bus.irq, bus.prog_start} !== 4'b0) begin
      failures++;
      $display("FAIL reset_outputs: busy/dma_en/irq/prog_start=%b required 0000",
               {bus.busy, bus.dma_en, bus.irq, bus.prog_start});
    end
    checks++;
    if (bus.vcount !== 15'd0) begin
      failures++;
      $display("FAIL reset_vcount: got %0d required 0", bus.vcount);
    end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_mesh_2x2();
    drive_mesh(1, 1, 0, 0, -1, -1, 200);
    checks++;
    if (timed_out) begin failures++; $display("FAIL m2x2_timeout: still busy after budget"); end
    checks++;
    if (seq_errs(1, 1) != 0) begin
      failures++;
      $display("FAIL m2x2_order: %0d bad vertices of %0d seen, required 0 of 4", seq_errs(1, 1), obs_r0.size());
    end
    checks++;
    if (n_irq != 1) begin failures++; $display("FAIL m2x2_irq: got %0d required 1", n_irq); end
    checks++;
    if (bus.vcount !== 15'd4) begin failures++; $display("FAIL m2x2_vcount: got %0d required 4", bus.vcount); end
  endtask

  task automatic test_mesh_1x1();
    drive_mesh(0, 0, 0, 0, -1, -1, 100);
    checks++;
    if (timed_out || n_ps != 1 || obs_r0.size() != 1) begin
      failures++;
      $display("FAIL m1x1_counts: prog_start=%0d dma=%0d timeout=%0d required 1 1 0", n_ps, obs_r0.size(), timed_out);
    end
    checks++;
    if (n_irq != 1) begin failures++; $display("FAIL m1x1_irq: got %0d required 1", n_irq); end
    checks++;
    if (bus.vcount !== 15'd1) begin failures++; $display("FAIL m1x1_vcount: got %0d required 1", bus.vcount); end
  endtask

  task automatic test_dma_hold();
    int bad = 0;
    drive_mesh(2, 0, 5, 1, -1, -1, 300);
    foreach (obs_len[i]) if (obs_len[i] != 6) bad++;
    checks++;
    if (timed_out || obs_len.size() != 3 || bad != 0) begin
      failures++;
      $display("FAIL dma_hold: writes=%0d wrong_lengths=%0d timeout=%0d required 3 0 0", obs_len.size(), bad, timed_out);
    end
    checks++;
    if (bus.vcount !== 15'd3 || n_irq != 1) begin
      failures++;
      $display("FAIL dma_hold_done: vcount=%0d irq=%0d required 3 1", bus.vcount, n_irq);
    end
  endtask

  task automatic test_random_meshes();
    for (int t = 0; t < 5; t++) begin
      int h = int'($urandom_range(0, 5));
      int v = int'($urandom_range(0, 4));
      int n = (h + 1) * (v + 1);
      drive_mesh(h, v, -1, 1, -1, -1, 2000);
      checks++;
      if (timed_out || seq_errs(h, v) != 0) begin
        failures++;
        $display("FAIL rand_order %0dx%0d: bad=%0d seen=%0d timeout=%0d required bad=0 seen=%0d",
                 h + 1, v + 1, seq_errs(h, v), obs_r0.size(), timed_out, n);
      end
      checks++;
      if (bus.vcount !== 15'(n) || n_irq != 1 || n_ps != n) begin
        failures++;
        $display("FAIL rand_counts %0dx%0d: vcount=%0d irq=%0d prog_start=%0d required %0d 1 %0d",
                 h + 1, v + 1, bus.vcount, n_irq, n_ps, n, n);
      end
    end
  endtask

  task automatic test_abort();
    drive_mesh(1, 1, 0, 1, 1, -1, 200);
    checks++;
    if (timed_out || obs_r0.size() != 2) begin
      failures++;
      $display("FAIL abort_stop: writes=%0d timeout=%0d required 2 0", obs_r0.size(), timed_out);
    end
    checks++;
    if (bus.vcount !== 15'd1) begin failures++; $display("FAIL abort_vcount: got %0d required 1", bus.vcount); end
    checks++;
    if (n_irq != 0 || bus.dma_en !== 1'b0) begin
      failures++;
      $display("FAIL abort_quiet: irq=%0d dma_en=%b required 0 0", n_irq, bus.dma_en);
    end
  endtask

  task automatic test_start_while_busy();
    drive_mesh(2, 1, 0, 1, -1, 2, 400);
    checks++;
    if (timed_out || seq_errs(2, 1) != 0) begin
      failures++;
      $display("FAIL busy_start_order: bad=%0d seen=%0d required bad=0 seen=6", seq_errs(2, 1), obs_r0.size());
    end
    checks++;
    if (bus.vcount !== 15'd6 || n_irq != 1) begin
      failures++;
      $display("FAIL busy_start_counts: vcount=%0d irq=%0d required 6 1", bus.vcount, n_irq);
    end
  endtask

  task automatic test_reset_in_dma();
    bit reached = 0;
    int irqs = 0;
    bus.hmesh_last = 7'd1; bus.vmesh_last = 7'd1;
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      bus.prog_done = bus.prog_start;
      bus.dma_ack = 1'b0;
      if (bus.dma_en) begin
        if (bus.vcount == 15'd1) begin
          reached = 1;
          break;
        end
        bus.dma_ack = 1'b1;
      end
      @(negedge sys_clk);
    end
    bus.prog_done = 1'b0; bus.dma_ack = 1'b0;
    checks++;
    if (!reached) begin failures++; $display("FAIL rst_dma_reach: second write not seen within budget"); end
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.dma_en !== 1'b0 || bus.vcount !== 15'd0) begin
      failures++;
      $display("FAIL rst_dma_async: busy=%b dma_en=%b vcount=%0d required 0 0 0", bus.busy, bus.dma_en, bus.vcount);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) begin
      @(negedge sys_clk);
      if (bus.irq) irqs++;
    end
    checks++;
    if (irqs != 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_dma_quiet: irq=%0d busy=%b required 0 0", irqs, bus.busy);
    end
    drive_mesh(1, 1, -1, 1, -1, -1, 300);
    checks++;
    if (timed_out || seq_errs(1, 1) != 0 || n_irq != 1) begin
      failures++;
      $display("FAIL rst_dma_restart: bad=%0d seen=%0d irq=%0d required 0 4 1", seq_errs(1, 1), obs_r0.size(), n_irq);
    end
  endtask

  task automatic test_mesh_128();
    drive_mesh(127, 127, 0, 0, -1, -1, 70000);
    checks++;
    if (timed_out || seq_errs(127, 127) != 0) begin
      failures++;
      $display("FAIL m128_order: bad=%0d seen=%0d timeout=%0d required 0 16384 0", seq_errs(127, 127), obs_r0.size(), timed_out);
    end
    checks++;
    if (bus.vcount !== 15'd16384 || n_irq != 1) begin
      failures++;
      $display("FAIL m128_counts: vcount=%0d irq=%0d required 16384 1", bus.vcount, n_irq);
    end
  endtask

  initial begin
    test_reset();
    test_mesh_2x2();
    test_mesh_1x1();
    test_dma_hold();
    test_random_meshes();
    test_abort();
    test_start_while_busy();
    test_reset_in_dma();
    test_mesh_128();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
